// File: rtl/eth_parser_pkg.sv
// Shared Ethernet parser types plus helpers used by the metadata merge stage.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;

  typedef struct packed {
    mac_addr_t   dest_mac;
    mac_addr_t   src_mac;
    logic [15:0] ethertype;
    logic        vlan_valid;
    logic [11:0] vlan_id;
    logic        is_ipv4;
    logic        is_ipv6;
    logic        is_arp;
    logic        frame_error;
  } eth_metadata_t;

  localparam int META_ARB_MAX_LANES = 8;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; search begins at the pointer, pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               j;

  always_comb begin
    any_req      = |req;
    grant_idx    = '0;
    grant_onehot = '0;
    found        = 1'b0;
    j            = 0;
    cand         = '0;
    for (int off = 0; off < N; off++) begin
      j    = (int'(ptr) + off) % N;
      cand = IDX_W'(j);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant_onehot[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any_req) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/metadata_arbiter.sv
// Merges per-lane packager records through one-entry slots and a round-robin
// arbiter onto a single registered valid/ready stream; collisions are dropped.
module metadata_arbiter
  import eth_parser_pkg::*;
#(
  parameter int  NUM_LANES = 4,
  parameter int  CNT_W     = 16,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] in_valid,
  input  eth_metadata_t        in_metadata [NUM_LANES],
  output logic                 out_valid,
  input  logic                 out_ready,
  output eth_metadata_t        out_metadata,
  output logic [LANE_W-1:0]    out_lane,
  output logic [NUM_LANES-1:0] drop_pulse,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 busy
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [3:0] inc);
    logic [CNT_W+4:0] sum;
    sum = {5'b00000, acc} + {{(CNT_W + 1){1'b0}}, inc};
    if (sum > {5'b00000, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  logic [NUM_LANES-1:0]          slot_full_p0;
  eth_metadata_t                 slot_data_p0 [NUM_LANES];
  logic                          vld_p1;
  eth_metadata_t                 data_p1;
  logic [LANE_W-1:0]             lane_p1;

  logic                          load_en;
  logic                          any_req;
  logic [NUM_LANES-1:0]          grant_onehot;
  logic [NUM_LANES-1:0]          grant;
  logic [NUM_LANES-1:0]          capture;
  logic [NUM_LANES-1:0]          drop_vec;
  logic [LANE_W-1:0]             grant_idx;
  logic [META_ARB_MAX_LANES-1:0] drop8;

  rr_arbiter #(.N(NUM_LANES)) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (slot_full_p0),
    .advance      (load_en),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_req      (any_req)
  );

  // A slot freed by this cycle's grant may accept a same-cycle arrival without a drop.
  always_comb begin
    load_en  = !vld_p1 || out_ready;
    grant    = grant_onehot & {NUM_LANES{load_en}};
    capture  = in_valid & (~slot_full_p0 | grant);
    drop_vec = in_valid & slot_full_p0 & ~grant;
    drop8    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      drop8[i] = drop_vec[i];
    end
  end

  // Stage p0: per-lane holding slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full_p0 <= '0;
    end else begin
      slot_full_p0 <= (slot_full_p0 & ~grant) | capture;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (capture[i]) slot_data_p0[i] <= in_metadata[i];
    end
  end

  // Stage p1: registered output and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      lane_p1    <= '0;
      drop_pulse <= '0;
      drop_count <= '0;
    end else begin
      if (load_en) begin
        vld_p1 <= any_req;
        if (any_req) begin
          data_p1 <= slot_data_p0[grant_idx];
          lane_p1 <= grant_idx;
        end
      end
      drop_pulse <= drop_vec;
      drop_count <= sat_add(drop_count, popcount8(drop8));
    end
  end

  assign out_valid    = vld_p1;
  assign out_metadata = data_p1;
  assign out_lane     = lane_p1;
  assign busy         = (|slot_full_p0) || vld_p1;

endmodule

// File: tb/tb_metadata_arbiter.sv
// Directed bench for metadata_arbiter: latency, ordering, backpressure, drops, saturation.
module tb_metadata_arbiter;
  import eth_parser_pkg::*;

  localparam int NL = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [NL-1:0] in_valid;
  eth_metadata_t in_md [NL];
  logic          out_valid;
  logic          out_ready;
  eth_metadata_t out_metadata;
  logic [1:0]    out_lane;
  logic [NL-1:0] drop_pulse;
  logic [CW-1:0] drop_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  metadata_arbiter #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_metadata  (in_md),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_metadata (out_metadata),
    .out_lane     (out_lane),
    .drop_pulse   (drop_pulse),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic eth_metadata_t mk(input logic [47:0] d, input logic [47:0] s,
                                       input logic [15:0] et);
    eth_metadata_t m;
    m           = '0;
    m.dest_mac  = d;
    m.src_mac   = s;
    m.ethertype = et;
    m.is_ipv4   = (et == 16'h0800);
    m.is_ipv6   = (et == 16'h86DD);
    m.is_arp    = (et == 16'h0806);
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    eth_metadata_t r1, r_a, r_b, r_p, r_q, hold;
    logic [15:0] ets [NL];
    ets[0] = 16'h0800; ets[1] = 16'h86DD; ets[2] = 16'h0806; ets[3] = 16'h1234;

    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NL; i++) in_md[i] = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_md",    256'(out_metadata), 256'(0));
    check("rst_out_lane",  256'(out_lane), 256'(0));
    check("rst_drop_cnt",  256'(drop_count), 256'(0));
    check("rst_drop_pls",  256'(drop_pulse), 256'(0));
    check("rst_busy",      256'(busy), 256'(0));
    do_reset();

    // Single record on lane 2
    r1 = mk(48'hAAAAAAAAAAAA, 48'h111111111111, 16'h0800);
    in_md[2] = r1;
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    check("t1_busy_slot",  256'(busy), 256'(1));
    check("t1_vld_early",  256'(out_valid), 256'(0));
    tick();
    check("t1_vld",        256'(out_valid), 256'(1));
    check("t1_lane",       256'(out_lane), 256'(2));
    check("t1_md",         256'(out_metadata), 256'(r1));
    tick();
    check("t1_vld_after",  256'(out_valid), 256'(0));
    check("t1_busy_after", 256'(busy), 256'(0));

    // Four-lane burst twice; order 0..3 both times
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NL; i++) in_md[i] = mk(48'h0, 48'(i + 16 * b), ets[i]);
      in_valid = 4'b1111;
      tick();
      in_valid = '0;
      for (int i = 0; i < NL; i++) begin
        tick();
        check("t2_vld",  256'(out_valid), 256'(1));
        check("t2_lane", 256'(out_lane), 256'(i));
        check("t2_et",   256'(out_metadata.ethertype), 256'(ets[i]));
        check("t2_src",  256'(out_metadata.src_mac), 256'(i + 16 * b));
      end
      tick();
      check("t2_drain", 256'(out_valid), 256'(0));
    end

    // Backpressure holds output; queued lanes 1 then 3 follow
    do_reset();
    r_a = mk(48'h0A0A0A0A0A0A, 48'h000000000001, 16'h0800);
    in_md[0] = r_a;
    in_valid = 4'b0001;
    tick();
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    check("t3_vld", 256'(out_valid), 256'(1));
    hold = out_metadata;
    in_md[1] = mk(48'h0, 48'h000000000101, 16'h86DD);
    in_md[3] = mk(48'h0, 48'h000000000303, 16'h1234);
    in_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      tick();
      in_valid = '0;
      check("t3_hold_vld",  256'(out_valid), 256'(1));
      check("t3_hold_lane", 256'(out_lane), 256'(0));
      check("t3_hold_md",   256'(out_metadata), 256'(r_a));
    end
    out_ready = 1'b1;
    tick();
    check("t3_next_lane", 256'(out_lane), 256'(1));
    check("t3_next_src",  256'(out_metadata.src_mac), 256'(48'h000000000101));
    tick();
    check("t3_last_lane", 256'(out_lane), 256'(3));
    check("t3_last_vld",  256'(out_valid), 256'(1));
    tick();
    check("t3_empty", 256'(out_valid), 256'(0));

    // Drop on a stalled full slot
    do_reset();
    out_ready = 1'b0;
    in_md[1] = mk(48'h0, 48'h00000000BEEF, 16'h0806);
    in_valid = 4'b0010;
    tick();
    in_valid = '0;
    tick();
    check("t4_stall_lane", 256'(out_lane), 256'(1));
    r_a = mk(48'h0, 48'hA1A1A1A1A1A1, 16'h0800);
    r_b = mk(48'h0, 48'hB2B2B2B2B2B2, 16'h0800);
    in_md[0] = r_a;
    in_valid = 4'b0001;
    tick();
    in_md[0] = r_b;
    tick();
    in_valid = '0;
    check("t4_pulse",     256'(drop_pulse), 256'(4'b0001));
    check("t4_count",     256'(drop_count), 256'(1));
    tick();
    check("t4_pulse_off", 256'(drop_pulse), 256'(0));
    check("t4_count_hld", 256'(drop_count), 256'(1));
    out_ready = 1'b1;
    tick();
    check("t4_out_lane",  256'(out_lane), 256'(0));
    check("t4_out_src",   256'(out_metadata.src_mac), 256'(48'hA1A1A1A1A1A1));
    tick();
    check("t4_no_second", 256'(out_valid), 256'(0));

    // Arrival into a slot granted in the same cycle
    do_reset();
    r_p = mk(48'h0, 48'h0000000000F1, 16'h0800);
    r_q = mk(48'h0, 48'h0000000000F2, 16'h86DD);
    in_md[1] = r_p;
    in_valid = 4'b0010;
    tick();
    in_md[1] = r_q;
    tick();
    in_valid = '0;
    check("t5_first",  256'(out_metadata), 256'(r_p));
    check("t5_nodrop", 256'(drop_pulse), 256'(0));
    tick();
    check("t5_second_vld", 256'(out_valid), 256'(1));
    check("t5_second", 256'(out_metadata), 256'(r_q));
    check("t5_lane",   256'(out_lane), 256'(1));
    check("t5_count",  256'(drop_count), 256'(0));

    // Saturating counter and asynchronous reset
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < NL; i++) in_md[i] = mk(48'h0, 48'(i), 16'h0800);
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    tick();
    in_valid = 4'b0011;
    tick();
    in_valid = 4'b0111;
    tick();
    check("t6_pulse2", 256'(drop_pulse), 256'(4'b0011));
    check("t6_count2", 256'(drop_count), 256'(2));
    in_valid = 4'b1111;
    tick();
    check("t6_pulse3", 256'(drop_pulse), 256'(4'b0111));
    check("t6_sat",    256'(drop_count), 256'(3));
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    check("t6_sat_hold", 256'(drop_count), 256'(3));
    check("t6_busy",     256'(busy), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_vld",  256'(out_valid), 256'(0));
    check("t6_rst_busy", 256'(busy), 256'(0));
    check("t6_rst_cnt",  256'(drop_count), 256'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
